// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 code p0=u^u1, p1=u^u1^u2.
// Four-state add-compare-select with register-exchange survivors and normalized, saturating metrics.
module viterbi_decoder_k3 #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  input  logic [1:0] parities,
  output logic       out_valid,
  output logic       out_bit
);
  localparam int CW    = PM_W + 2;
  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam logic [CW-1:0]    PM_MAX   = CW'((1 << PM_W) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);

  logic [3:0][PM_W-1:0]     pm_q, pm_d;
  logic [3:0][TB_DEPTH-1:0] sv_q, sv_d;
  logic [3:0][CW-1:0]       acs_metric;
  logic [3:0][CW-1:0]       norm_metric;
  logic [CNT_W-1:0]         cnt_q;
  logic                     out_valid_q, out_bit_q;
  logic [CW-1:0]            min_metric;
  logic [1:0]               min_idx;

  // New state gi = {u, a}; its predecessors are {a,0} and {a,1}.
  for (genvar gi = 0; gi < 4; gi++) begin : g_acs
    localparam logic     U    = 1'(gi / 2);
    localparam logic     A    = 1'(gi % 2);
    localparam int       P0   = 2 * (gi % 2);
    localparam int       P1   = P0 + 1;
    localparam logic [1:0] EXP0 = {U ^ A, U ^ A};
    localparam logic [1:0] EXP1 = {~(U ^ A), U ^ A};

    logic [1:0]    diff0, diff1;
    logic [CW-1:0] cand0, cand1;
    logic          take1;

    assign diff0 = parities ^ EXP0;
    assign diff1 = parities ^ EXP1;
    assign cand0 = CW'(pm_q[P0]) + CW'(diff0[0]) + CW'(diff0[1]);
    assign cand1 = CW'(pm_q[P1]) + CW'(diff1[0]) + CW'(diff1[1]);
    // Strict compare so the {a,0} predecessor keeps ties.
    assign take1 = cand1 < cand0;
    assign acs_metric[gi] = take1 ? cand1 : cand0;
    assign sv_d[gi] = {take1 ? sv_q[P1][TB_DEPTH-2:0] : sv_q[P0][TB_DEPTH-2:0], U};
  end

  always_comb begin
    min_metric = acs_metric[0];
    min_idx    = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (acs_metric[i] < min_metric) begin
        min_metric = acs_metric[i];
        min_idx    = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      norm_metric[i] = acs_metric[i] - min_metric;
      pm_d[i] = (norm_metric[i] > PM_MAX) ? PM_MAX[PM_W-1:0] : norm_metric[i][PM_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pm_q        <= {PM_W'(4), PM_W'(4), PM_W'(4), PM_W'(0)};
      sv_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (in_valid) begin
        pm_q        <= pm_d;
        sv_q        <= sv_d;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        out_valid_q <= (cnt_q >= CNT_LAST);
        out_bit_q   <= sv_d[min_idx][TB_DEPTH-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Self-checking bench for viterbi_decoder_k3: directed streams, mid-stream reset,
// random-error metric bounds against a trellis model, and a long error-free golden run.
module tb_viterbi_decoder_k3;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] parities = 2'b00;
  logic       ov5, ob5, ov15, ob15;

  int checks = 0;
  int errors = 0;

  bit enc_a, enc_b;

  int       m_pm[4];
  bit [31:0] m_sv[4];
  int       m_cnt;
  bit       m_ob;

  always #5 CLK = ~CLK;

  viterbi_decoder_k3 #(.TB_DEPTH(5), .PM_W(4)) dut5 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .parities(parities),
    .out_valid(ov5), .out_bit(ob5)
  );

  viterbi_decoder_k3 #(.TB_DEPTH(15), .PM_W(4)) dut15 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .parities(parities),
    .out_valid(ov15), .out_bit(ob15)
  );

  task automatic drive(input logic r, input logic v, input logic [1:0] p);
    @(negedge CLK);
    RST = r;
    in_valid = v;
    parities = p;
    @(posedge CLK);
    #1;
  endtask

  // Reference encoder: returns {p1,p0} and advances the history.
  task automatic encode(input bit u, output logic [1:0] p);
    p = {u ^ enc_a ^ enc_b, u ^ enc_a};
    enc_b = enc_a;
    enc_a = u;
  endtask

  function automatic bit [1:0] branch_pair(input bit u, input bit a, input bit b);
    return {u ^ a ^ b, u ^ a};
  endfunction

  task automatic model_reset();
    m_pm = '{0, 4, 4, 4};
    for (int s = 0; s < 4; s++) m_sv[s] = '0;
    m_cnt = 0;
    m_ob = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
  endtask

  // Trellis model: visit every (predecessor, input) branch and keep the best arrival.
  task automatic model_step(input int depth, input bit [1:0] r, output bit ov);
    int        npm[4];
    bit [31:0] nsv[4];
    bit [31:0] mask;
    int        best, mn, ns, c;
    bit [1:0]  e;
    mask = (32'h1 << depth) - 1;
    for (int s = 0; s < 4; s++) begin npm[s] = 1 << 20; nsv[s] = '0; end
    for (int p = 0; p < 4; p++) begin
      for (int u = 0; u < 2; u++) begin
        ns = 2 * u + p / 2;
        e  = branch_pair(u[0], p[1], p[0]);
        c  = m_pm[p] + int'(r[0] ^ e[0]) + int'(r[1] ^ e[1]);
        if (c < npm[ns]) begin
          npm[ns] = c;
          nsv[ns] = ((m_sv[p] << 1) | 32'(u)) & mask;
        end
      end
    end
    mn = npm[0]; best = 0;
    for (int s = 1; s < 4; s++) if (npm[s] < mn) begin mn = npm[s]; best = s; end
    for (int s = 0; s < 4; s++) begin
      m_pm[s] = (npm[s] - mn > 15) ? 15 : npm[s] - mn;
      m_sv[s] = nsv[s];
    end
    ov = (m_cnt + 1 >= depth);
    if (m_cnt < depth) m_cnt++;
    m_ob = nsv[best][depth-1];
  endtask

  task automatic apply_reset();
    drive(1'b1, 1'b0, 2'b00);
    model_reset();
  endtask

  task automatic test_reset();
    int rst_pm[4] = '{0, 4, 4, 4};
    drive(1'b1, 1'b1, 2'b11);
    model_reset();
    checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL reset_ov5 got %b expected 0", ov5); end
    checks++; if (ob5 !== 1'b0) begin errors++; $display("FAIL reset_ob5 got %b expected 0", ob5); end
    checks++; if (ov15 !== 1'b0) begin errors++; $display("FAIL reset_ov15 got %b expected 0", ov15); end
    checks++; if (ob15 !== 1'b0) begin errors++; $display("FAIL reset_ob15 got %b expected 0", ob15); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut5.pm_q[i] !== 4'(rst_pm[i])) begin
        errors++; $display("FAIL reset_pm5[%0d] got %0d expected %0d", i, dut5.pm_q[i], rst_pm[i]);
      end
      checks++;
      if (dut15.pm_q[i] !== 4'(rst_pm[i])) begin
        errors++; $display("FAIL reset_pm15[%0d] got %0d expected %0d", i, dut15.pm_q[i], rst_pm[i]);
      end
    end
    $display("reset: ov5=%b ob5=%b ov15=%b ob15=%b", ov5, ob5, ov15, ob15);
  endtask

  // Directed 8-bit stream on the depth-5 decoder with an optional flipped p1 and idle gaps.
  task automatic run_stream(input string name, input int flip_pair, input int gaps);
    bit         u_dir[8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    logic [1:0] p;
    bit         last, exp_v;
    apply_reset();
    last = 1'b0;
    for (int k = 0; k < 8; k++) begin
      encode(u_dir[k], p);
      if (k == flip_pair) p ^= 2'b10;
      drive(1'b0, 1'b1, p);
      exp_v = (k >= 4);
      checks++;
      if (ov5 !== exp_v) begin
        errors++; $display("FAIL %s_valid pair %0d got %b expected %b", name, k, ov5, exp_v);
      end
      if (exp_v) begin
        last = u_dir[k-4];
        checks++;
        if (ob5 !== last) begin
          errors++; $display("FAIL %s_bit pair %0d got %b expected %b", name, k, ob5, last);
        end
      end
      $display("%s: pair %0d in=%b%b out_valid=%b out_bit=%b", name, k, p[1], p[0], ov5, ob5);
      for (int g = 0; g < gaps; g++) begin
        drive(1'b0, 1'b0, 2'($urandom_range(0, 3)));
        checks++;
        if (ov5 !== 1'b0 || ob5 !== last) begin
          errors++; $display("FAIL %s_gap pair %0d got v=%b b=%b expected v=0 b=%b", name, k, ov5, ob5, last);
        end
      end
    end
  endtask

  task automatic test_error_free();   run_stream("clean", -1, 0); endtask
  task automatic test_single_error(); run_stream("err1", 2, 0);   endtask
  task automatic test_gaps();         run_stream("gaps", -1, 3);  endtask

  task automatic test_mid_reset();
    int         rst_pm[4] = '{0, 4, 4, 4};
    bit         nu[5];
    logic [1:0] p;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      encode(1'($urandom_range(0, 1)), p);
      drive(1'b0, 1'b1, p);
      checks++;
      if (ov5 !== 1'b0) begin errors++; $display("FAIL midrst_pre pair %0d got %b expected 0", k, ov5); end
    end
    encode(1'b1, p);
    drive(1'b1, 1'b1, p);
    model_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut5.pm_q[i] !== 4'(rst_pm[i])) begin
        errors++; $display("FAIL midrst_pm[%0d] got %0d expected %0d", i, dut5.pm_q[i], rst_pm[i]);
      end
    end
    checks++;
    if (ov5 !== 1'b0 || ob5 !== 1'b0) begin
      errors++; $display("FAIL midrst_out got v=%b b=%b expected v=0 b=0", ov5, ob5);
    end
    for (int j = 0; j < 5; j++) begin
      nu[j] = 1'($urandom_range(0, 1));
      encode(nu[j], p);
      drive(1'b0, 1'b1, p);
      checks++;
      if (ov5 !== (j == 4)) begin
        errors++; $display("FAIL midrst_valid pair %0d got %b expected %b", j, ov5, (j == 4));
      end
      $display("midrst: pair %0d in=%b%b out_valid=%b out_bit=%b", j, p[1], p[0], ov5, ob5);
    end
    checks++;
    if (ob5 !== nu[0]) begin errors++; $display("FAIL midrst_bit got %b expected %b", ob5, nu[0]); end
  endtask

  task automatic test_random_errors();
    logic [1:0] p;
    bit         v, exp_v;
    int         mx, mn;
    apply_reset();
    for (int n = 0; n < 10000; n++) begin
      v = ($urandom_range(0, 7) != 0);
      exp_v = 1'b0;
      if (v) begin
        encode(1'($urandom_range(0, 1)), p);
        if ($urandom_range(0, 9) == 0) p ^= 2'b01;
        if ($urandom_range(0, 9) == 0) p ^= 2'b10;
        model_step(5, p, exp_v);
      end else begin
        p = 2'($urandom_range(0, 3));
      end
      drive(1'b0, v, p);
      checks++;
      if (ov5 !== exp_v || ob5 !== m_ob) begin
        errors++; $display("FAIL rand_out n=%0d got v=%b b=%b expected v=%b b=%b", n, ov5, ob5, exp_v, m_ob);
      end
      mx = 0; mn = 1 << 20;
      for (int i = 0; i < 4; i++) begin
        if (int'(dut5.pm_q[i]) > mx) mx = int'(dut5.pm_q[i]);
        if (int'(dut5.pm_q[i]) < mn) mn = int'(dut5.pm_q[i]);
        checks++;
        if (int'(dut5.pm_q[i]) != m_pm[i]) begin
          errors++; $display("FAIL rand_pm[%0d] n=%0d got %0d expected %0d", i, n, dut5.pm_q[i], m_pm[i]);
        end
      end
      checks++;
      if (mx > 15 || mn != 0) begin
        errors++; $display("FAIL rand_bound n=%0d got max=%0d min=%0d expected max<=15 min=0", n, mx, mn);
      end
      if (n % 1000 == 999) $display("random: %0d pairs, checks=%0d", n + 1, checks);
    end
  endtask

  task automatic test_golden();
    bit         gu[2000];
    logic [1:0] p;
    apply_reset();
    for (int k = 0; k < 2000; k++) begin
      gu[k] = 1'($urandom_range(0, 1));
      encode(gu[k], p);
      drive(1'b0, 1'b1, p);
      checks++;
      if (ov15 !== (k >= 14)) begin
        errors++; $display("FAIL golden_valid k=%0d got %b expected %b", k, ov15, (k >= 14));
      end
      if (k >= 14) begin
        checks++;
        if (ob15 !== gu[k-14]) begin
          errors++; $display("FAIL golden_bit k=%0d got %b expected %b", k, ob15, gu[k-14]);
        end
      end
    end
    $display("golden: 2000 bits decoded, checks=%0d", checks);
  endtask

  initial begin
    test_reset();
    test_error_free();
    test_single_error();
    test_gaps();
    test_mid_reset();
    test_random_errors();
    test_golden();
    drive(1'b0, 1'b0, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
